// File: rtl/cs_pkg.sv
// Shared types and constants for the cs frame sequencer.
package cs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;
    localparam logic [1:0] ERR_EXT  = 2'b10;

    localparam int unsigned CS_NSTG_DEF = 4;

endpackage

// File: rtl/cs_seq_tmr.sv
// Per-stage watchdog: saturating up-counter, cleared on every stage entry.
module cs_seq_tmr #(
    parameter int unsigned TMO_W   = 16,
    parameter int unsigned TMO_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    if ((TMO_CYC >> TMO_W) != 0) begin : g_tmo_range
        $error("cs_seq_tmr: TMO_CYC does not fit in TMO_W bits");
    end

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // TMO_CYC == 0 disables the watchdog entirely.
    assign hit = en && (cnt_q == TMO_LAST) && (TMO_CYC != 0);

endmodule

// File: rtl/cs_seq.sv
// Frame sequencer: walks one frame through NSTG fs/fd stages with back-pressure,
// per-stage timeout, error abort and a completed-frame counter.
module cs_seq
    import cs_pkg::*;
#(
    parameter int unsigned NSTG    = CS_NSTG_DEF,
    parameter int unsigned NFULL   = 3,
    parameter int unsigned TMO_W   = 16,
    parameter int unsigned TMO_CYC = 50000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fs_in,
    output logic                    fd_out,
    input  logic [NFULL-1:0]        fifo_full,
    output logic [NSTG-1:0]         fs_stg,
    input  logic [NSTG-1:0]         fd_stg,
    input  logic                    err_in,
    input  logic                    err_clr,
    output logic                    busy,
    output logic [$clog2(NSTG)-1:0] cur_stg,
    output logic                    err_flag,
    output logic [1:0]              err_code,
    output logic [$clog2(NSTG)-1:0] err_stg,
    output logic [CNT_W-1:0]        frame_cnt,
    output logic [2:0]              state_dbg
);

    if (NSTG < 2 || NSTG > 16) begin : g_nstg_range
        $error("cs_seq: NSTG must be in 2..16");
    end

    localparam int unsigned SW = $clog2(NSTG);
    localparam logic [SW-1:0]   LAST = SW'(NSTG - 1);
    localparam logic [NSTG-1:0] STG0 = NSTG'(1);

    // Handshake: fs_stg[i] is a level held for the whole stage; the stage
    // finishes when fd_stg[i] is seen high while it is the current stage.
    state_t            state_q, state_d;
    logic [SW-1:0]     stg_q, stg_d;
    logic [NSTG-1:0]   fs_stg_q, fs_stg_d;
    logic              fd_out_q, fd_out_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              err_flag_q, err_flag_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [SW-1:0]     err_stg_q, err_stg_d;
    logic              busy_q, busy_d;
    logic [SW-1:0]     cur_stg_q, cur_stg_d;
    logic              tmr_clr, tmr_en, tmr_hit;

    cs_seq_tmr #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_tmr (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .hit (tmr_hit)
    );

    always_comb begin
        state_d     = state_q;
        stg_d       = stg_q;
        fs_stg_d    = fs_stg_q;
        fd_out_d    = fd_out_q;
        frame_cnt_d = frame_cnt_q;
        err_flag_d  = err_flag_q;
        err_code_d  = err_code_q;
        err_stg_d   = err_stg_q;
        tmr_clr     = 1'b1;
        tmr_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fs_in) begin
                    if (|fifo_full) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d  = ST_RUN;
                        stg_d    = '0;
                        fs_stg_d = STG0;
                    end
                end
            end
            ST_HOLD: begin
                if (!fs_in) begin
                    state_d = ST_IDLE;
                end else if (!(|fifo_full)) begin
                    state_d  = ST_RUN;
                    stg_d    = '0;
                    fs_stg_d = STG0;
                end
            end
            ST_RUN: begin
                tmr_clr = 1'b0;
                tmr_en  = 1'b1;
                // External error outranks a done in the same cycle, which in
                // turn outranks a timeout landing on that cycle.
                if (err_in) begin
                    state_d    = ST_ERR;
                    fs_stg_d   = '0;
                    err_flag_d = 1'b1;
                    err_code_d = ERR_EXT;
                    err_stg_d  = stg_q;
                end else if (fd_stg[stg_q]) begin
                    if (stg_q == LAST) begin
                        state_d     = ST_DONE;
                        fs_stg_d    = '0;
                        fd_out_d    = 1'b1;
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end else begin
                        stg_d    = stg_q + SW'(1);
                        fs_stg_d = fs_stg_q << 1;
                        tmr_clr  = 1'b1;
                    end
                end else if (tmr_hit) begin
                    state_d    = ST_ERR;
                    fs_stg_d   = '0;
                    err_flag_d = 1'b1;
                    err_code_d = ERR_TMO;
                    err_stg_d  = stg_q;
                end
            end
            ST_DONE: begin
                if (!fs_in) begin
                    state_d  = ST_IDLE;
                    fd_out_d = 1'b0;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_d    = ST_IDLE;
                    err_flag_d = 1'b0;
                    err_code_d = ERR_NONE;
                    err_stg_d  = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                fs_stg_d = '0;
                fd_out_d = 1'b0;
            end
        endcase
        busy_d    = (state_d == ST_HOLD) || (state_d == ST_RUN) || (state_d == ST_DONE);
        cur_stg_d = (state_d == ST_RUN) ? stg_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stg_q       <= '0;
            fs_stg_q    <= '0;
            fd_out_q    <= 1'b0;
            frame_cnt_q <= '0;
            err_flag_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_stg_q   <= '0;
            busy_q      <= 1'b0;
            cur_stg_q   <= '0;
        end else begin
            state_q     <= state_d;
            stg_q       <= stg_d;
            fs_stg_q    <= fs_stg_d;
            fd_out_q    <= fd_out_d;
            frame_cnt_q <= frame_cnt_d;
            err_flag_q  <= err_flag_d;
            err_code_q  <= err_code_d;
            err_stg_q   <= err_stg_d;
            busy_q      <= busy_d;
            cur_stg_q   <= cur_stg_d;
        end
    end

    assign fs_stg    = fs_stg_q;
    assign fd_out    = fd_out_q;
    assign frame_cnt = frame_cnt_q;
    assign err_flag  = err_flag_q;
    assign err_code  = err_code_q;
    assign err_stg   = err_stg_q;
    assign busy      = busy_q;
    assign cur_stg   = cur_stg_q;
    assign state_dbg = state_q;

endmodule

// File: doc/cs_seq.md
Name: cs_seq

Overview:
- Parametrised successor to the fixed-pipeline command sequencer in the cs control block.
- Runs one frame through a chain of NSTG downstream stages, such as UDP rx → MAC→FIFO → FIFO→CS → length calc.
- Each stage uses an fs/fd level handshake; FIFO-full back-pressure gates frame start.
- Adds what the fixed version lacks: a per-stage timeout, an abort on error with a recorded error cause and stage, and a frame counter.

Parameters:
- NSTG, 4, number of sequenced stages (2..16).
- NFULL, 3, number of FIFO-full back-pressure inputs.
- TMO_W, 16, width of the per-stage timeout counter.
- TMO_CYC, 16'd50000, cycles allowed per stage before timeout; 0 disables the timeout.
- CNT_W, 16, width of the frame counter.

Ports:
- clk, in, 1: system clock (sys_clk domain).
- rst, in, 1: synchronous reset, active-high.
- fs_in, in, 1: frame-start request from upstream, held as a level.
- fd_out, out, 1: frame done to upstream.
- fifo_full, in, NFULL: back-pressure; any bit set blocks a new frame.
- fs_stg, out, NSTG: one-hot per-stage start.
- fd_stg, in, NSTG: per-stage done.
- err_in, in, 1: external error (e.g. err_fifoc2cs).
- err_clr, in, 1: clears the error state.
- busy, out, 1: high in HOLD, RUN or DONE.
- cur_stg, out, $clog2(NSTG): index of the active stage.
- err_flag, out, 1: sticky error.
- err_code, out, 2: 00 none, 01 timeout, 10 external error.
- err_stg, out, $clog2(NSTG): stage active when the error occurred.
- frame_cnt, out, CNT_W: number of completed frames.

Behaviour:
- All outputs are registered.
- Reset value of every output is 0; state returns to IDLE.
- rst asserted mid-frame drops all fs_stg on the next edge; no done is reported.
- States: IDLE, HOLD, RUN, DONE, ERR.
- IDLE:
  - fs_in=1 and fifo_full==0 → RUN, stg=0; fs_stg[0]=1 on the next cycle (1-cycle latency).
  - fs_in=1 and any fifo_full bit set → HOLD.
- HOLD: stays until fifo_full==0, then → RUN as above.
  - If fs_in drops while in HOLD → IDLE.
- RUN:
  - fs_stg = one-hot(stg); the timer counts from 0.
  - fd_stg[stg]=1 with stg<NSTG-1: next cycle stg+1, fs_stg moves to the next bit (no gap, never two bits set), timer reset to 0.
  - fd_stg[stg]=1 with stg==NSTG-1: fs_stg=0 next cycle → DONE.
  - fd_stg bits of non-current stages are ignored.
  - TMO_CYC≠0 and timer==TMO_CYC-1 without fd → ERR with err_code=01, err_stg=stg.
  - err_in=1 → ERR with err_code=10, err_stg=stg.
- Priority within a cycle: err_in > fd_stg[stg] > timeout.
  - fd and timeout in the same cycle: the stage advances.
  - fd and err_in in the same cycle: go to ERR.
- err_in is ignored outside RUN.
- fifo_full is not re-checked after RUN is entered.
- DONE:
  - fd_out=1 and frame_cnt increments once, both on DONE entry.
  - frame_cnt wraps from all-ones to 0.
  - fd_out is held until fs_in=0; fd_out=0 on the next cycle → IDLE.
- ERR:
  - fs_stg=0, fd_out=0, err_flag=1; err_code and err_stg are frozen.
  - err_clr=1 → IDLE next cycle; err_flag, err_code and err_stg clear to 0.
  - err_clr outside ERR has no effect.
- Timer: TMO_W-bit, saturating, reset on every stage entry.
- TMO_CYC must fit in TMO_W bits (checked at elaboration).
- cur_stg reflects stg during RUN; 0 otherwise.

Decomposition:
- Package cs_pkg:
  - state enum (IDLE, HOLD, RUN, DONE, ERR);
  - err_code constants ERR_NONE, ERR_TMO, ERR_EXT;
  - CS_NSTG_DEF.
- Sub-module cs_seq_tmr: the loadable, saturating stage timer.
  - Ports clk, rst, clr, en, hit.
  - hit = en & (cnt==TMO_CYC-1) & (TMO_CYC≠0).
- FSM, stage pointer and frame counter stay in cs_seq.

Test Plan:
- Nominal, NSTG=4:
  - Stimulus: fs_in rises; each fd_stg[i] is answered 3 cycles after fs_stg[i].
  - Required: fs_stg goes 0001, 0010, 0100, 1000, 0000.
  - Required: fd_out=1 one cycle after fd_stg[3]; frame_cnt=1; fd_out falls 1 cycle after fs_in falls.
- Back-pressure:
  - Stimulus: fifo_full=3'b010 while fs_in rises; fifo_full clears at cycle 10.
  - Required: busy=1, fs_stg=0 during cycles 1..10; fs_stg[0]=1 at cycle 11.
- Timeout:
  - Stimulus: TMO_CYC=8; fd_stg[2] is never answered.
  - Required: 8 cycles after fs_stg[2] rises, err_flag=1, err_code=01, err_stg=2, fs_stg=0.
  - Then err_clr=1 → IDLE, err_flag=0.
- Priority:
  - Stimulus: err_in and fd_stg[1] in the same cycle.
  - Required: err_code=10, err_stg=1, frame_cnt unchanged.
  - Stimulus: fd_stg[stg] arriving on the timeout cycle.
  - Required: the stage advances, no error.
- Wrap and reset:
  - Stimulus: CNT_W=4, run 16 frames.
  - Required: frame_cnt reads 0 after the 16th frame.
  - Stimulus: rst asserted during stage 2.
  - Required: all outputs 0 the next cycle.
